// File: rtl/mac_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_unit_pkg
//  Description : Shared sizing helpers for the MAC datapath. Provides the
//                accumulator width rule (twice the operand width) and the
//                signed min/max patterns used when clamping an accumulate
//                that overflows.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_unit_pkg;

    // Widest accumulator the helpers below can describe.
    localparam int c_max_width = 128;

    // The accumulator is twice the operand width, so the full product fits.
    function automatic int acc_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Largest signed value of a w-bit word (0111...1), right-aligned.
    function automatic logic [c_max_width-1:0] sat_max(input int w);
        return (c_max_width'(1) << (w - 1)) - c_max_width'(1);
    endfunction

    // Smallest signed value of a w-bit word (1000...0), right-aligned.
    function automatic logic [c_max_width-1:0] sat_min(input int w);
        return c_max_width'(1) << (w - 1);
    endfunction

endpackage : mac_unit_pkg
`default_nettype wire

// File: rtl/mac_unit_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : mac_sat_add
//  Description : Combinational signed adder with optional saturation.
//                The sum is formed one bit wider than the operands; the
//                result is either truncated (wrap) or clamped to the signed
//                range of WIDTH bits when the wide sum does not fit.
//  Ports       : i_a   [WIDTH-1:0] signed addend
//                i_b   [WIDTH-1:0] signed addend
//                o_sum [WIDTH-1:0] signed sum (wrapped or saturated)
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_sat_add
    import mac_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] c_min = WIDTH'(sat_min(WIDTH));

    logic [WIDTH:0] w_sum_ext;
    logic           w_ovf;

    // Sign-extend both addends by one bit so the true sum is always exact.
    assign w_sum_ext = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

    // The wide sum fits in WIDTH bits only when its top two bits agree.
    assign w_ovf = w_sum_ext[WIDTH] ^ w_sum_ext[WIDTH-1];

    generate
        if (SATURATE) begin : g_sat
            // The extra top bit is the true sign: 1 means negative overflow.
            always_comb begin
                o_sum = w_sum_ext[WIDTH-1:0];
                if (w_ovf) begin
                    o_sum = w_sum_ext[WIDTH] ? c_min : c_max;
                end
            end
        end else begin : g_wrap
            logic w_unused_ovf;
            assign w_unused_ovf = w_ovf;
            assign o_sum        = w_sum_ext[WIDTH-1:0];
        end
    endgenerate

endmodule : mac_sat_add
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mac_unit
//  Description : Signed multiply-accumulate cell for PE/systolic arrays.
//                Every cycle: acc_out <= acc_in + a * b. Accumulation is
//                external; acc_out is purely registered so it may be fed
//                straight back into acc_in or chained to a neighbour.
//  Ports       : clk     rising-edge clock
//                rst     synchronous active-high reset (acc_out <= 0)
//                a       [DATA_WIDTH-1:0]   signed multiplicand
//                b       [DATA_WIDTH-1:0]   signed multiplier
//                acc_in  [2*DATA_WIDTH-1:0] signed incoming partial sum
//                acc_out [2*DATA_WIDTH-1:0] signed registered result
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    input  logic [2*DATA_WIDTH-1:0]   acc_in,
    output logic [2*DATA_WIDTH-1:0]   acc_out
);

    localparam int c_acc_width = acc_width(DATA_WIDTH);

    logic signed [c_acc_width-1:0] w_a_ext;
    logic signed [c_acc_width-1:0] w_b_ext;
    logic signed [c_acc_width-1:0] w_prod;
    logic        [c_acc_width-1:0] w_sum;
    logic        [c_acc_width-1:0] r_acc;

    // Operands are sign-extended to the accumulator width before the
    // multiply; the full signed product always fits, even (-2^(DW-1))^2.
    assign w_a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign w_b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    mac_sat_add #(
        .WIDTH    (c_acc_width),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .i_a   (acc_in),
        .i_b   (w_prod),
        .o_sum (w_sum)
    );

    // Reset wins over the datapath, so unknown inputs during reset never
    // reach the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum;
        end
    end

    assign acc_out = r_acc;

endmodule : mac_unit
`default_nettype wire

// File: tb/tb_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_unit
//  Description : Self-checking bench for mac_unit. Runs a wrapping and a
//                saturating instance side by side on shared inputs and
//                compares both against an integer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_unit;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] a   = '0;
    logic signed [15:0] b   = '0;
    logic signed [31:0] acc_in = '0;
    logic        [31:0] acc_out_wrap;
    logic        [31:0] acc_out_sat;

    int total = 0;
    int bad   = 0;

    // Expected outputs currently held by each instance.
    logic [31:0] r_exp_wrap = '0;
    logic [31:0] r_exp_sat  = '0;
    bit          r_valid    = 1'b0;

    always #5 clk = ~clk;

    mac_unit #(.DATA_WIDTH(16), .SATURATE(1'b0)) u_dut_wrap (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .acc_in  (acc_in),
        .acc_out (acc_out_wrap)
    );

    mac_unit #(.DATA_WIDTH(16), .SATURATE(1'b1)) u_dut_sat (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .acc_in  (acc_in),
        .acc_out (acc_out_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap to 32 bits or clamp.
    function automatic logic [31:0] ref_mac(input logic signed [15:0] ia,
                                           input logic signed [15:0] ib,
                                           input logic signed [31:0] iacc,
                                           input bit sat);
        longint s;
        s = longint'(iacc) + longint'(ia) * longint'(ib);
        if (sat) begin
            if (s > 64'sd2147483647)  s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
        end
        return s[31:0];
    endfunction

    // One clock: drive on the falling edge, confirm outputs have not moved
    // before the rising edge, then check the registered result after it.
    task automatic step(input string tag, input bit r,
                        input logic signed [15:0] ia, input logic signed [15:0] ib,
                        input logic signed [31:0] iacc, input bit check_hold);
        @(negedge clk);
        rst    = r;
        a      = ia;
        b      = ib;
        acc_in = iacc;
        #1;
        if (check_hold && r_valid) begin
            check({tag, "_hold_wrap"}, acc_out_wrap, r_exp_wrap);
            check({tag, "_hold_sat"},  acc_out_sat,  r_exp_sat);
        end
        r_exp_wrap = r ? 32'd0 : ref_mac(ia, ib, iacc, 1'b0);
        r_exp_sat  = r ? 32'd0 : ref_mac(ia, ib, iacc, 1'b1);
        r_valid    = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_wrap"}, acc_out_wrap, r_exp_wrap);
        check({tag, "_sat"},  acc_out_sat,  r_exp_sat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [15:0] ra;
        logic signed [15:0] rb;
        logic signed [31:0] racc;
        bit                 rr;

        // Reset held for two edges with live inputs.
        step("reset0", 1'b1, 16'sd5, 16'sd5, 32'sd7, 1'b0);
        step("reset1", 1'b1, 16'sd5, 16'sd5, 32'sd7, 1'b1);

        // Accumulate chain with feedback.
        step("chain0", 1'b0, 16'sd10, 16'sd5,  32'sd0,  1'b1);
        step("chain1", 1'b0, -16'sd3, 16'sd4,  32'sd50, 1'b1);
        step("chain2", 1'b0, 16'sd7,  -16'sd8, 32'sd38, 1'b1);

        // Reset mid-stream, then resume from the cleared value.
        step("midrst", 1'b1, 16'sd9, 16'sd9, -32'sd18, 1'b1);
        step("resume", 1'b0, 16'sd2, 16'sd3, 32'sd0,   1'b1);

        // Extreme products.
        step("prod_minmin", 1'b0, -16'sd32768, -16'sd32768, 32'sd0, 1'b1);
        step("prod_minmax", 1'b0, -16'sd32768, 16'sd32767,  32'sd0, 1'b1);

        // Accumulate overflow, positive then negative.
        step("ovf_pos", 1'b0, 16'sd1,  16'sd1, 32'sh7fffffff, 1'b1);
        step("ovf_neg", 1'b0, -16'sd1, 16'sd1, 32'sh80000000, 1'b1);
        step("ovf_big", 1'b0, -16'sd32768, -16'sd32768, 32'sh60000000, 1'b1);

        // Zero operand passes acc_in through with one cycle of delay.
        step("pass", 1'b0, 16'sd0, 16'sd1234, -32'sd99, 1'b1);

        // Randomized mix of feedback, fresh partial sums and resets.
        for (int i = 0; i < 300; i++) begin
            ra   = 16'($urandom());
            rb   = 16'($urandom());
            rr   = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       racc = r_exp_wrap;
                1:       racc = r_exp_sat;
                2:       racc = 32'($urandom()) ^ 32'h8000_0000;
                default: racc = 32'($urandom());
            endcase
            step("rand", rr, ra, rb, racc, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mac_unit
`default_nettype wire

// File: doc/mac_unit.md
Name: mac_unit

Overview:
- Signed multiply-accumulate cell for the ViT accelerator datapath, the building block of systolic/PE arrays.
- Each cycle it multiplies two signed operands, adds an externally supplied partial sum, and registers the result.
- Accumulation is external: the caller feeds acc_out back into acc_in, or chains it to a neighbouring PE.

Parameters:
- DATA_WIDTH, 16, width of signed operands a and b; accumulator width is 2*DATA_WIDTH.
- SATURATE, 0, 0 = two's-complement wrap on accumulate overflow; 1 = clamp to signed min/max of 2*DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous active-high reset.
- a  input  DATA_WIDTH  signed multiplicand.
- b  input  DATA_WIDTH  signed multiplier.
- acc_in  input  2*DATA_WIDTH  signed incoming partial sum.
- acc_out  output  2*DATA_WIDTH  signed registered result.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- Reset: on a rising clk edge with rst=1, acc_out <= 0. Inputs are ignored that cycle. rst has priority over every other operation.
- Normal operation: on each rising edge with rst=0, acc_out <= acc_in + (a * b).
- Latency is exactly 1 cycle. Throughput is one result per cycle. There is no enable and no handshake; the unit computes every cycle.
- Arithmetic:
  - a and b are sign-extended and multiplied to a full signed 2*DATA_WIDTH product.
  - The product never overflows. The extreme case (-2^(DW-1))^2 = 2^(2DW-2) fits.
- Addition:
  - The sum is computed at 2*DATA_WIDTH+1 bits internally.
  - SATURATE=0: the result is truncated to 2*DATA_WIDTH bits (wrap-around).
  - SATURATE=1: positive overflow clamps to 2^(2DW-1)-1; negative overflow clamps to -2^(2DW-1).
- Feedback: acc_out is purely registered (no combinational path from inputs to acc_out), so driving acc_in from acc_out forms a legal accumulator loop.
- Reset mid-stream: the accumulated value is lost and acc_out reads 0 on the following cycle. Normal operation resumes the next edge after rst falls.
- Zero operands: acc_out equals acc_in registered (pass-through with 1-cycle delay).
- X on inputs while rst=1 must not propagate to acc_out.

Decomposition:
- Shared package: accumulator width function/constant ACC_WIDTH = 2*DATA_WIDTH, and signed min/max constants for ACC_WIDTH used by the saturation logic.
- One natural sub-module: mac_sat_add, a combinational signed adder with optional saturation parameterized by width. It is reused by adder trees elsewhere.
- The multiply is inferred (DSP mapping).

Test Plan:
- Reset: hold rst=1 for 2 edges with a=5, b=5, acc_in=7 -> acc_out=0.
- Accumulate chain (DW=16, inputs changed mid-cycle):
  - a=10, b=5, acc_in=0 -> acc_out=50 next edge.
  - Then a=-3, b=4, acc_in=50 -> 38.
  - Then a=7, b=-8, acc_in=38 -> -18.
- Extreme product: a=-32768, b=-32768, acc_in=0 -> 1073741824. Also a=-32768, b=32767, acc_in=0 -> -1073709056.
- Overflow: acc_in=2147483647, a=1, b=1.
  - SATURATE=0 -> acc_out=-2147483648.
  - SATURATE=1 -> 2147483647.
  - Negative case: acc_in=-2147483648, a=-1, b=1, SATURATE=1 -> -2147483648.
- Reset mid-operation: during the accumulate chain, assert rst for one edge -> acc_out=0. Release with a=2, b=3, acc_in=acc_out -> 6 next edge.
- Pass-through: a=0, b=1234, acc_in=-99 -> acc_out=-99 after exactly one edge, unchanged before the edge.
